// File: rtl/cpu_alu_issue_pkg.sv
// Shared CPU ALU encodings: opcodes, operand-select values and the issue-queue entry layout.
// Opcode values are owned here so the decoder, this issue block and the ALU agree.
package cpu_alu_issue_pkg;

    localparam logic [5:0] OP_SIGNED_ADD = 6'd0;
    localparam logic [5:0] OP_SUB        = 6'd1;
    localparam logic [5:0] OP_AND        = 6'd2;
    localparam logic [5:0] OP_OR         = 6'd3;
    localparam logic [5:0] OP_XOR        = 6'd4;

    typedef enum logic { OP1_SEL_RS1 = 1'b0, OP1_SEL_PC  = 1'b1 } op1_sel_e;
    typedef enum logic { OP2_SEL_RS2 = 1'b0, OP2_SEL_IMM = 1'b1 } op2_sel_e;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        logic [31:0] pc;
        logic [31:0] imm;
        op1_sel_e    op1_sel;
        op2_sel_e    op2_sel;
        logic [4:0]  rd;
    } issue_op_t;

    // x0 is hardwired zero, so a producer targeting it never forwards.
    function automatic logic bypass_hit(input logic prod_vld, input logic [4:0] prod_rd,
                                        input logic [4:0] src_idx);
        return prod_vld && (prod_rd != 5'd0) && (prod_rd == src_idx);
    endfunction

endpackage

// File: rtl/cpu_alu_issue_fifo.sv
// Two-entry skid FIFO with 1-bit wrapping pointers; head is read combinationally.
// Push when full and pop when empty are ignored.
module cpu_alu_issue_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/cpu_alu_issue.sv
// ALU issue stage: buffers operations, drives an external ALU from the queue head and
// registers its result, forwarding that result to the next head's register operands.
module cpu_alu_issue
    import cpu_alu_issue_pkg::*;
#(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 i_reset,
    input  logic                 i_clock,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [5:0]           i_op,
    input  logic [31:0]          i_rs1,
    input  logic [31:0]          i_rs2,
    input  logic [4:0]           i_rs1_idx,
    input  logic [4:0]           i_rs2_idx,
    input  logic [31:0]          i_pc,
    input  logic [31:0]          i_imm,
    input  logic                 i_op1_sel,
    input  logic                 i_op2_sel,
    input  logic [4:0]           i_rd,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic [5:0]           o_alu_op,
    output logic [31:0]          o_alu_op1,
    output logic [31:0]          o_alu_op2,
    input  logic [31:0]          i_alu_result,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_result,
    output logic [4:0]           o_rd,
    output logic [TAG_WIDTH-1:0] o_tag
);

    localparam int ENTRY_W = $bits(issue_op_t) + TAG_WIDTH;

    issue_op_t              w_in_op;
    issue_op_t              w_head_op;
    logic [TAG_WIDTH-1:0]   w_head_tag;
    logic [ENTRY_W-1:0]     w_head;
    logic [1:0]             w_count;
    logic                   w_push;
    logic                   w_adv;
    logic                   w_byp1;
    logic                   w_byp2;

    logic                   r_vld_p1;
    logic [31:0]            r_result_p1;
    logic [4:0]             r_rd_p1;
    logic [TAG_WIDTH-1:0]   r_tag_p1;

    assign w_in_op = '{op: i_op, rs1: i_rs1, rs2: i_rs2, rs1_idx: i_rs1_idx,
                       rs2_idx: i_rs2_idx, pc: i_pc, imm: i_imm,
                       op1_sel: op1_sel_e'(i_op1_sel), op2_sel: op2_sel_e'(i_op2_sel),
                       rd: i_rd};

    // o_ready depends only on the registered count, never on i_ready.
    assign o_ready = (w_count != 2'd2);
    assign w_push  = i_valid && o_ready;
    assign w_adv   = (!r_vld_p1 || i_ready) && (w_count != 2'd0);

    cpu_alu_issue_fifo #(.WIDTH(ENTRY_W)) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_adv),
        .i_data  ({w_in_op, i_tag}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign {w_head_op, w_head_tag} = w_head;

    // p0: head operands, with the registered result forwarded into rs-selected sources.
    assign w_byp1 = (w_head_op.op1_sel == OP1_SEL_RS1) &&
                    bypass_hit(r_vld_p1, r_rd_p1, w_head_op.rs1_idx);
    assign w_byp2 = (w_head_op.op2_sel == OP2_SEL_RS2) &&
                    bypass_hit(r_vld_p1, r_rd_p1, w_head_op.rs2_idx);

    assign o_alu_op  = w_head_op.op;
    assign o_alu_op1 = (w_head_op.op1_sel == OP1_SEL_PC) ? w_head_op.pc :
                       (w_byp1 ? r_result_p1 : w_head_op.rs1);
    assign o_alu_op2 = (w_head_op.op2_sel == OP2_SEL_IMM) ? w_head_op.imm :
                       (w_byp2 ? r_result_p1 : w_head_op.rs2);

    // p1: result register, held while the consumer stalls.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_vld_p1    <= 1'b0;
            r_result_p1 <= '0;
            r_rd_p1     <= '0;
            r_tag_p1    <= '0;
        end else if (w_adv) begin
            r_vld_p1    <= 1'b1;
            r_result_p1 <= i_alu_result;
            r_rd_p1     <= w_head_op.rd;
            r_tag_p1    <= w_head_tag;
        end else if (r_vld_p1 && i_ready) begin
            r_vld_p1    <= 1'b0;
        end
    end

    assign o_valid  = r_vld_p1;
    assign o_result = r_result_p1;
    assign o_rd     = r_rd_p1;
    assign o_tag    = r_tag_p1;

endmodule

// File: tb/tb_cpu_alu_issue.sv
// Directed bench for cpu_alu_issue with a behavioural ALU on the o_alu_* / i_alu_result ports.
module tb_cpu_alu_issue;
    import cpu_alu_issue_pkg::*;

    localparam int TW = 4;

    logic          i_reset = 1'b1;
    logic          i_clock = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [5:0]    i_op = '0;
    logic [31:0]   i_rs1 = '0, i_rs2 = '0, i_pc = '0, i_imm = '0;
    logic [4:0]    i_rs1_idx = '0, i_rs2_idx = '0, i_rd = '0;
    logic          i_op1_sel = 1'b0, i_op2_sel = 1'b0;
    logic [TW-1:0] i_tag = '0;
    logic [5:0]    o_alu_op;
    logic [31:0]   o_alu_op1, o_alu_op2;
    logic [31:0]   i_alu_result;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic [31:0]   o_result;
    logic [4:0]    o_rd;
    logic [TW-1:0] o_tag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clock = ~i_clock;

    always_comb begin
        i_alu_result = 32'h0;
        case (o_alu_op)
            OP_SIGNED_ADD: i_alu_result = o_alu_op1 + o_alu_op2;
            OP_SUB:        i_alu_result = o_alu_op1 - o_alu_op2;
            OP_AND:        i_alu_result = o_alu_op1 & o_alu_op2;
            OP_OR:         i_alu_result = o_alu_op1 | o_alu_op2;
            OP_XOR:        i_alu_result = o_alu_op1 ^ o_alu_op2;
            default:       i_alu_result = 32'h0;
        endcase
    end

    cpu_alu_issue #(.TAG_WIDTH(TW)) dut (
        .i_reset(i_reset), .i_clock(i_clock), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs1_idx(i_rs1_idx),
        .i_rs2_idx(i_rs2_idx), .i_pc(i_pc), .i_imm(i_imm), .i_op1_sel(i_op1_sel),
        .i_op2_sel(i_op2_sel), .i_rd(i_rd), .i_tag(i_tag), .o_alu_op(o_alu_op),
        .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2), .i_alu_result(i_alu_result),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_rd(o_rd),
        .o_tag(o_tag)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] ia, input logic [4:0] ib, input logic [4:0] rd,
                         input logic [TW-1:0] tag, input logic s1, input logic s2,
                         input logic [31:0] pc, input logic [31:0] imm);
        i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_rs1_idx = ia; i_rs2_idx = ib;
        i_rd = rd; i_tag = tag; i_op1_sel = s1; i_op2_sel = s2; i_pc = pc; i_imm = imm;
    endtask

    task automatic idle();
        i_valid = 1'b0;
    endtask

    task automatic step();
        @(negedge i_clock);
    endtask

    task automatic chk_out(input string name, input logic [31:0] res, input logic [4:0] rd);
        chk({name, ".valid"}, {31'h0, o_valid}, 32'h1);
        chk({name, ".result"}, o_result, res);
        chk({name, ".rd"}, {27'h0, o_rd}, {27'h0, rd});
    endtask

    initial begin
        // reset state
        repeat (2) step();
        chk("rst.valid", {31'h0, o_valid}, 32'h0);
        chk("rst.ready", {31'h0, o_ready}, 32'h1);
        chk("rst.result", o_result, 32'h0);
        chk("rst.rd", {27'h0, o_rd}, 32'h0);
        chk("rst.tag", {28'h0, o_tag}, 32'h0);

        // first op accepted on the first edge after release, result one clock later
        i_reset = 1'b0;
        drive(OP_SIGNED_ADD, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 4'd1, 1'b0, 1'b0, 0, 0);
        step();
        idle();
        chk("add.pre_valid", {31'h0, o_valid}, 32'h0);
        chk("add.alu_op1", o_alu_op1, 32'd5);
        chk("add.alu_op2", o_alu_op2, 32'd7);
        step();
        chk_out("add", 32'd12, 5'd3);
        chk("add.tag", {28'h0, o_tag}, 32'h1);
        step();
        chk("add.drain", {31'h0, o_valid}, 32'h0);

        // back-to-back rs1 bypass
        drive(OP_SIGNED_ADD, 32'd1, 32'd1, 5'd1, 5'd2, 5'd3, 4'd2, 1'b0, 1'b0, 0, 0);
        step();
        drive(OP_SIGNED_ADD, 32'd0, 32'd10, 5'd3, 5'd5, 5'd4, 4'd3, 1'b0, 1'b0, 0, 0);
        step();
        idle();
        chk_out("byp1.prod", 32'd2, 5'd3);
        chk("byp1.ready", {31'h0, o_ready}, 32'h1);
        step();
        chk_out("byp1.cons", 32'd12, 5'd4);
        step();

        // rs2 bypass
        drive(OP_SIGNED_ADD, 32'd20, 32'd2, 5'd1, 5'd2, 5'd12, 4'd4, 1'b0, 1'b0, 0, 0);
        step();
        drive(OP_SUB, 32'd100, 32'd0, 5'd1, 5'd12, 5'd13, 4'd5, 1'b0, 1'b0, 0, 0);
        step();
        idle();
        chk_out("byp2.prod", 32'd22, 5'd12);
        step();
        chk_out("byp2.cons", 32'd78, 5'd13);
        step();

        // backpressure: one at output, two buffered, fourth offer ignored
        i_ready = 1'b0;
        drive(OP_SIGNED_ADD, 32'd10, 32'd1, 5'd1, 5'd2, 5'd5, 4'd6, 1'b0, 1'b0, 0, 0);
        step();
        drive(OP_SUB, 32'd10, 32'd3, 5'd1, 5'd2, 5'd6, 4'd7, 1'b0, 1'b0, 0, 0);
        step();
        drive(OP_XOR, 32'hF0, 32'h0F, 5'd1, 5'd2, 5'd7, 4'd8, 1'b0, 1'b0, 0, 0);
        chk("bp.ready_c1", {31'h0, o_ready}, 32'h1);
        step();
        drive(OP_OR, 32'h1, 32'h2, 5'd1, 5'd2, 5'd8, 4'd9, 1'b0, 1'b0, 0, 0);
        chk("bp.ready_full", {31'h0, o_ready}, 32'h0);
        chk_out("bp.hold0", 32'd11, 5'd5);
        step();
        idle();
        chk_out("bp.hold1", 32'd11, 5'd5);
        chk("bp.tag_hold", {28'h0, o_tag}, 32'h6);
        i_ready = 1'b1;
        step();
        chk_out("bp.r2", 32'd7, 5'd6);
        step();
        chk_out("bp.r3", 32'hFF, 5'd7);
        step();
        chk("bp.no_dup", {31'h0, o_valid}, 32'h0);
        step();
        chk("bp.no_4th", {31'h0, o_valid}, 32'h0);

        // pc/imm select never bypassed
        drive(OP_SIGNED_ADD, 32'd100, 32'd1, 5'd1, 5'd2, 5'd9, 4'd1, 1'b0, 1'b0, 0, 0);
        step();
        drive(OP_SIGNED_ADD, 32'hDEAD, 32'hBEEF, 5'd9, 5'd9, 5'd10, 4'd2, 1'b1, 1'b1,
              32'h100, 32'd4);
        step();
        idle();
        chk_out("sel.prod", 32'd101, 5'd9);
        chk("sel.alu_op1", o_alu_op1, 32'h100);
        chk("sel.alu_op2", o_alu_op2, 32'd4);
        step();
        chk_out("sel.cons", 32'h104, 5'd10);
        step();

        // rd=0 producer does not forward to rs1_idx=0
        drive(OP_SIGNED_ADD, 32'd3, 32'd4, 5'd1, 5'd2, 5'd0, 4'd3, 1'b0, 1'b0, 0, 0);
        step();
        drive(OP_SIGNED_ADD, 32'd0, 32'd5, 5'd0, 5'd1, 5'd11, 4'd4, 1'b0, 1'b0, 0, 0);
        step();
        idle();
        chk_out("x0.prod", 32'd7, 5'd0);
        step();
        chk_out("x0.cons", 32'd5, 5'd11);
        step();

        // reset mid-operation with a full queue and a held result
        i_ready = 1'b0;
        drive(OP_SIGNED_ADD, 32'd1, 32'd1, 5'd1, 5'd2, 5'd20, 4'd5, 1'b0, 1'b0, 0, 0);
        step();
        drive(OP_SIGNED_ADD, 32'd2, 32'd2, 5'd1, 5'd2, 5'd21, 4'd6, 1'b0, 1'b0, 0, 0);
        step();
        drive(OP_SIGNED_ADD, 32'd3, 32'd3, 5'd1, 5'd2, 5'd22, 4'd7, 1'b0, 1'b0, 0, 0);
        step();
        idle();
        chk("mid.full", {31'h0, o_ready}, 32'h0);
        chk("mid.valid", {31'h0, o_valid}, 32'h1);
        #1 i_reset = 1'b1;
        #1;
        chk("mid.rst_valid", {31'h0, o_valid}, 32'h0);
        chk("mid.rst_ready", {31'h0, o_ready}, 32'h1);
        chk("mid.rst_result", o_result, 32'h0);
        step();
        i_reset = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid.no_stale", {31'h0, o_valid}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
